// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 8-bit sequencer.
// Command values, init length, FSM states and the init wait selector.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_POWERON,
        S_LOAD,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_EXEC,
        S_IDLE
    } state_e;

    typedef enum logic [1:0] {
        W_INIT1,
        W_INIT2,
        W_EXEC,
        W_LONG
    } wait_sel_e;

    typedef struct packed {
        logic [7:0] data;
        wait_sel_e  wsel;
    } rom_entry_t;

    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_FUNC_8B  = 8'h30;
    localparam logic [7:0] CMD_FUNC_2L  = 8'h38;
    localparam logic [7:0] CMD_DISP_OFF = 8'h08;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;

    localparam int INIT_LEN = 7;

    // Clear (0x01) and the two return-home encodings (0x02/0x03) need the long wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Power-on init sequence: maps step index to the byte written and
// which execution wait follows it. Purely combinational.
module lcd_init_rom
    import lcd_pkg::*;
(
    input  logic [2:0] idx,
    output rom_entry_t entry
);

    always_comb begin
        entry = '{data: CMD_ENTRY, wsel: W_EXEC};
        case (idx)
            3'd0:    entry = '{data: CMD_FUNC_8B,  wsel: W_INIT1};
            3'd1:    entry = '{data: CMD_FUNC_8B,  wsel: W_INIT2};
            3'd2:    entry = '{data: CMD_FUNC_8B,  wsel: W_EXEC};
            3'd3:    entry = '{data: CMD_FUNC_2L,  wsel: W_EXEC};
            3'd4:    entry = '{data: CMD_DISP_OFF, wsel: W_EXEC};
            3'd5:    entry = '{data: CMD_CLEAR,    wsel: W_LONG};
            default: entry = '{data: CMD_ENTRY,    wsel: W_EXEC};
        endcase
    end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 8-bit write sequencer: autonomous power-on init, then one host
// byte per valid/ready handshake with setup/pulse/hold and execution waits.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_POWERON   = 750000,
    parameter int T_INIT1     = 205000,
    parameter int T_INIT2     = 5000,
    parameter int T_SETUP     = 2,
    parameter int T_PULSE     = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 80000,
    parameter int CW          = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

    state_e        state, state_nxt;
    logic [CW-1:0] timer;
    logic [CW-1:0] t_len;
    logic [CW-1:0] exec_len;
    logic [2:0]    idx;
    rom_entry_t    rom;
    logic          t_done;
    logic          accept;

    logic          en_d, ready_d, busy_d, done_d, rs_d;
    logic [7:0]    data_d;

    lcd_init_rom u_rom (
        .idx   (idx),
        .entry (rom)
    );

    assign lcd_rw = 1'b0;
    assign accept = req_valid && req_ready;

    // During init the ROM picks the wait; afterwards it follows the latched byte.
    always_comb begin
        exec_len = CW'(T_EXEC);
        if (!init_done) begin
            case (rom.wsel)
                W_INIT1: exec_len = CW'(T_INIT1);
                W_INIT2: exec_len = CW'(T_INIT2);
                W_LONG:  exec_len = CW'(T_EXEC_LONG);
                default: exec_len = CW'(T_EXEC);
            endcase
        end else if (is_long_cmd(lcd_rs, lcd_data)) begin
            exec_len = CW'(T_EXEC_LONG);
        end
    end

    always_comb begin
        case (state)
            S_POWERON: t_len = CW'(T_POWERON);
            S_SETUP:   t_len = CW'(T_SETUP);
            S_PULSE:   t_len = CW'(T_PULSE);
            S_HOLD:    t_len = CW'(T_HOLD);
            S_EXEC:    t_len = exec_len;
            default:   t_len = CW'(1);
        endcase
    end

    // Timer counts 0..T-1 within a state, so a state of length T lasts T cycles.
    assign t_done = (timer == t_len - CW'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_POWERON: if (t_done) state_nxt = S_LOAD;
            S_LOAD:    state_nxt = S_SETUP;
            S_SETUP:   if (t_done) state_nxt = S_PULSE;
            S_PULSE:   if (t_done) state_nxt = S_HOLD;
            S_HOLD:    if (t_done) state_nxt = S_EXEC;
            S_EXEC: begin
                if (t_done) begin
                    if (!init_done && idx != 3'(INIT_LEN - 1))
                        state_nxt = S_LOAD;
                    else
                        state_nxt = S_IDLE;
                end
            end
            S_IDLE:    if (accept) state_nxt = S_SETUP;
            default:   state_nxt = S_POWERON;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up
    // exactly with the state they describe.
    always_comb begin
        en_d    = (state_nxt == S_PULSE);
        ready_d = (state_nxt == S_IDLE);
        busy_d  = (state_nxt != S_IDLE);
        done_d  = init_done || (state == S_EXEC && state_nxt == S_IDLE);
        rs_d    = lcd_rs;
        data_d  = lcd_data;
        if (state == S_LOAD) begin
            rs_d   = 1'b0;
            data_d = rom.data;
        end else if (state == S_IDLE && accept) begin
            rs_d   = req_rs;
            data_d = req_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_POWERON;
            timer     <= '0;
            idx       <= '0;
            lcd_en    <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            init_done <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || state == S_IDLE)
                timer <= '0;
            else
                timer <= timer + CW'(1);
            if (state == S_EXEC && state_nxt == S_LOAD)
                idx <= idx + 3'd1;
            lcd_en    <= en_d;
            lcd_rs    <= rs_d;
            lcd_data  <= data_d;
            req_ready <= ready_d;
            busy      <= busy_d;
            init_done <= done_d;
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl: expected E pulses are queued as stimulus is
// driven and popped by a pulse monitor; handshake timing checked inline.
module tb_lcd_ctrl;

    localparam int T_POWERON   = 10;
    localparam int T_INIT1     = 6;
    localparam int T_INIT2     = 4;
    localparam int T_SETUP     = 2;
    localparam int T_PULSE     = 3;
    localparam int T_HOLD      = 2;
    localparam int T_EXEC      = 5;
    localparam int T_EXEC_LONG = 9;

    localparam int LAT_SHORT = T_SETUP + T_PULSE + T_HOLD + T_EXEC;
    localparam int LAT_LONG  = T_SETUP + T_PULSE + T_HOLD + T_EXEC_LONG;
    // Release edge to first E rise: POWERON, one LOAD cycle, SETUP.
    localparam int FIRST_RISE = T_POWERON + 1 + T_SETUP;

    localparam logic [7:0] INIT_SEQ [7] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06};
    localparam int INIT_WAIT [6] = '{T_INIT1, T_INIT2, T_EXEC, T_EXEC, T_EXEC, T_EXEC_LONG};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, init_done, busy, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .T_POWERON(T_POWERON), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2),
        .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD),
        .T_EXEC(T_EXEC), .T_EXEC_LONG(T_EXEC_LONG), .CW(20)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_rs(req_rs),
        .req_data(req_data), .req_ready(req_ready), .init_done(init_done),
        .busy(busy), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_data(lcd_data)
    );

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   rises[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor: pops one expected byte per E rise, checks width and that
    // RS/DATA stay put through the pulse and the hold window after it.
    initial begin
        logic en_prev;
        int   width;
        int   hold_left;
        exp_t cur;
        en_prev = 1'b0;
        width = 0;
        hold_left = 0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                en_prev = 1'b0;
                hold_left = 0;
            end else begin
                check("lcd_rw", lcd_rw, 1'b0);
                if (hold_left > 0) begin
                    check("hold_data", {lcd_rs, lcd_data}, cur);
                    hold_left--;
                end
                if (lcd_en && !en_prev) begin
                    pulses++;
                    rises.push_back(cyc);
                    width = 1;
                    check("pulse_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) cur = exp_q.pop_front();
                    else cur = {lcd_rs, lcd_data};
                    check("pulse_rs", lcd_rs, cur.rs);
                    check("pulse_data", lcd_data, cur.data);
                end else if (lcd_en) begin
                    width++;
                    check("pulse_stable", {lcd_rs, lcd_data}, cur);
                end else if (en_prev) begin
                    check("pulse_width", width, T_PULSE);
                    check("hold_data", {lcd_rs, lcd_data}, cur);
                    hold_left = T_HOLD - 1;
                end
                en_prev = lcd_en;
            end
        end
    end

    task automatic push_init();
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, INIT_SEQ[i]});
    endtask

    // Called at a negedge with reset high; releases it and follows init to IDLE.
    task automatic run_init(input string tag);
        int t0;
        int n;
        push_init();
        rises.delete();
        reset = 1'b0;
        t0 = cyc;
        n = 0;
        while (!init_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, init_done, 1'b1);
        check({tag, "_pulses"}, rises.size(), 7);
        if (rises.size() == 7) begin
            check({tag, "_first_rise"}, rises[0] - t0, FIRST_RISE);
            for (int i = 0; i < 6; i++)
                check({tag, "_gap"}, rises[i+1] - rises[i],
                      T_PULSE + T_HOLD + INIT_WAIT[i] + 1 + T_SETUP);
            check({tag, "_done_time"}, cyc - rises[6], T_PULSE + T_HOLD + T_EXEC);
        end
        check({tag, "_ready"}, req_ready, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // Called at a negedge while IDLE; one-cycle valid, then waits for ready.
    task automatic send(input logic rs, input logic [7:0] d, input int exp_lat);
        int acc;
        int n;
        req_valid = 1'b1;
        req_rs = rs;
        req_data = d;
        exp_q.push_back({rs, d});
        @(negedge clk);
        acc = cyc;
        req_valid = 1'b0;
        check("acc_rs", lcd_rs, rs);
        check("acc_data", lcd_data, d);
        check("acc_ready_low", req_ready, 1'b0);
        check("acc_busy", busy, 1'b1);
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_latency", cyc - acc, exp_lat);
        if (rises.size() > 0)
            check("e_rise_latency", rises[rises.size()-1] - acc, T_SETUP);
    endtask

    initial begin
        int acc1;
        int acc2;
        int n;
        int p0;

        repeat (3) @(negedge clk);
        check("rst_en", lcd_en, 1'b0);
        check("rst_rs", lcd_rs, 1'b0);
        check("rst_rw", lcd_rw, 1'b0);
        check("rst_data", lcd_data, 8'h00);
        check("rst_ready", req_ready, 1'b0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_busy", busy, 1'b1);

        run_init("init");

        send(1'b1, 8'h41, LAT_SHORT);
        send(1'b0, 8'h01, LAT_LONG);
        send(1'b0, 8'h02, LAT_LONG);
        send(1'b0, 8'h04, LAT_SHORT);
        send(1'b0, 8'h80, LAT_SHORT);
        send(1'b1, 8'h01, LAT_SHORT);

        // Back-to-back with valid held: ready returns LAT_SHORT after the first
        // accept and the second accept lands on that first IDLE cycle's edge.
        req_valid = 1'b1;
        req_rs = 1'b1;
        req_data = 8'h48;
        exp_q.push_back({1'b1, 8'h48});
        @(negedge clk);
        acc1 = cyc;
        check("b2b_data0", lcd_data, 8'h48);
        req_data = 8'h49;
        exp_q.push_back({1'b1, 8'h49});
        n = 0;
        while (lcd_data != 8'h49 && n < 100) begin
            @(negedge clk);
            n++;
        end
        acc2 = cyc;
        req_valid = 1'b0;
        check("b2b_spacing", acc2 - acc1, LAT_SHORT + 1);
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b_ready_latency", cyc - acc2, LAT_SHORT);

        // Valid pulsed while busy must be ignored.
        req_valid = 1'b1;
        req_rs = 1'b1;
        req_data = 8'h42;
        exp_q.push_back({1'b1, 8'h42});
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_rs = 1'b0;
        req_data = 8'h55;
        @(negedge clk);
        req_valid = 1'b0;
        check("busy_ignore_data", lcd_data, 8'h42);
        check("busy_ignore_rs", lcd_rs, 1'b1);
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        p0 = pulses;
        repeat (5) @(negedge clk);
        check("busy_ignore_pulses", pulses, p0);
        check("busy_ignore_idle_data", lcd_data, 8'h42);
        check("busy_ignore_ready", req_ready, 1'b1);
        check("busy_ignore_queue", exp_q.size(), 0);

        // Reset in the middle of an E pulse.
        req_valid = 1'b1;
        req_rs = 1'b1;
        req_data = 8'h5A;
        exp_q.push_back({1'b1, 8'h5A});
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!lcd_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_reset_in_pulse", lcd_en, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("mid_reset_en", lcd_en, 1'b0);
        check("mid_reset_init_done", init_done, 1'b0);
        check("mid_reset_busy", busy, 1'b1);
        check("mid_reset_ready", req_ready, 1'b0);
        check("mid_reset_data", lcd_data, 8'h00);
        repeat (3) @(negedge clk);
        run_init("reinit");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
